// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converters: FSM state type,
// digit width, and the binary width needed to hold a DIGITS-digit decimal.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_conv_state_t;

  localparam int BCD_DIGIT_W = 4;

  // ceil(log2(10^digits)): smallest width w with 2^w >= 10^digits.
  function automatic int bcd_bin_width(input int digits);
    longint p;
    int     w;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    w = 0;
    for (int b = 0; b < 40; b++) begin
      if ((longint'(1) << b) < p) w = b + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_to_binary_seq_digit_correct.sv
// Per-digit correction for reverse double-dabble: after the right shift a
// nibble that reads 8 or more held a 10s weight that must become 5, so 3 is
// subtracted. Purely combinational.
module bcd_digit_correct
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] corrected
);

  // Subtract 3 from any nibble of 8 or more; no borrow crosses nibbles.
  always_comb begin
    corrected = digit;
    if (digit >= 4'd8) corrected = digit - 4'd3;
  end

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One shift-and-correct step per clock, BIN_WIDTH steps per conversion, so
// latency is fixed regardless of the digits presented.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is high only in IDLE; out_valid is high only in DONE and
// the result is held unchanged until out_ready is seen with it. Upstream and
// downstream must hold their data/valid until the transfer edge.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BIN_WIDTH = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIN_WIDTH-1:0]          out_binary,
  output logic                          out_error,
  output bcd_conv_state_t               dbg_state
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_WIDTH;
  localparam int CNT_W  = $clog2(BIN_WIDTH + 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_to_binary_seq: DIGITS must be in 1..8");
  end
  if (BIN_WIDTH != bcd_bin_width(DIGITS)) begin : g_bad_width
    $error("bcd_to_binary_seq: BIN_WIDTH must equal ceil(log2(10**DIGITS))");
  end

  bcd_conv_state_t    state;
  bcd_conv_state_t    next_state;
  logic [WORK_W-1:0]  work;
  logic [CNT_W-1:0]   count;
  logic               err;
  logic               any_bad;
  logic               last_step;
  logic [WORK_W-1:0]  shifted;
  logic [BCD_W-1:0]   bcd_fixed;
  logic [WORK_W-1:0]  step_work;

  assign shifted   = work >> 1;
  assign last_step = (count == CNT_W'(BIN_WIDTH - 1));
  assign step_work = {bcd_fixed, shifted[BIN_WIDTH-1:0]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_correct u_correct (
      .digit     (shifted[BIN_WIDTH + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .corrected (bcd_fixed[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Flag an input that contains any nibble outside 0..9.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_bcd[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9) any_bad = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state: accept in IDLE, BIN_WIDTH steps in SHIFT, hold in DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = SHIFT;
      SHIFT:   if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Work register, step counter and error flag; the counter holds in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= {in_bcd, {BIN_WIDTH{1'b0}}};
            count <= '0;
            err   <= any_bad;
          end
        end
        SHIFT: begin
          work  <= step_work;
          count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; the result is only visible in DONE.
  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == DONE);
    out_error  = (state == DONE) && err;
    out_binary = '0;
    if (state == DONE && !err) out_binary = work[BIN_WIDTH-1:0];
    dbg_state  = state;
  end

  // A valid BCD input must be fully drained into the binary field.
  a_bcd_drained : assert property (
    @(posedge clk) disable iff (reset)
    (state == DONE && !err) |-> (work[WORK_W-1:BIN_WIDTH] == '0)
  );

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: a 4-digit and a 2-digit instance share the
// clock and reset. A latency-level model predicts every output each cycle;
// directed cases pin literal results; the 2-digit instance gets a full sweep.
module tb_bcd_to_binary_seq;
  import bcd_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // Channel 0 drives the 4-digit DUT, channel 1 the 2-digit DUT.
  logic        in_valid_s [2];
  logic        out_ready_s[2];
  logic [15:0] in_bcd_s   [2];

  logic        in_ready4, out_valid4, out_error4;
  logic [13:0] out_binary4;
  logic        in_ready2, out_valid2, out_error2;
  logic [6:0]  out_binary2;
  bcd_conv_state_t dbg_state4, dbg_state2;

  int passed = 0;
  int total  = 0;

  // Model state per channel.
  bit          m_busy[2];
  bit          m_done[2];
  int          m_cnt [2];
  logic [13:0] m_bin [2];
  logic        m_err [2];

  // Sweep scoreboard.
  logic [6:0] exp_q[$];
  bit         sweep_on   = 1'b0;
  bit         sweep_done = 1'b0;
  int         rx_count   = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.DIGITS(4), .BIN_WIDTH(14)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_s[0]), .in_ready(in_ready4), .in_bcd(in_bcd_s[0]),
    .out_valid(out_valid4), .out_ready(out_ready_s[0]),
    .out_binary(out_binary4), .out_error(out_error4), .dbg_state(dbg_state4)
  );

  bcd_to_binary_seq #(.DIGITS(2), .BIN_WIDTH(7)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid_s[1]), .in_ready(in_ready2), .in_bcd(in_bcd_s[1][7:0]),
    .out_valid(out_valid2), .out_ready(out_ready_s[1]),
    .out_binary(out_binary2), .out_error(out_error2), .dbg_state(dbg_state2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Decimal meaning of the lowest nd digits; error if any digit exceeds 9.
  function automatic void ref_conv(input logic [15:0] bcd, input int nd,
                                   output logic [13:0] val, output logic err);
    int acc;
    int d;
    acc = 0;
    err = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) err = 1'b1;
      acc = acc * 10 + d;
    end
    val = err ? 14'd0 : 14'(acc);
  endfunction

  // Model: accept when idle, result appears BIN_WIDTH edges later, held
  // until out_ready, then idle again.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0;
        m_done[k] = 1'b0;
        m_cnt[k]  = 0;
      end else if (m_done[k]) begin
        if (out_ready_s[k]) m_done[k] = 1'b0;
      end else if (m_busy[k]) begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
        end
      end else if (in_valid_s[k]) begin
        m_busy[k] = 1'b1;
        m_cnt[k]  = (k == 0) ? 14 : 7;
        ref_conv(in_bcd_s[k], (k == 0) ? 4 : 2, m_bin[k], m_err[k]);
      end
    end
  end

  // Compare every output of both DUTs against the model each cycle.
  always @(negedge clk) begin
    logic        idle0, idle1;
    logic [13:0] eb0, eb1;
    idle0 = !m_busy[0] && !m_done[0];
    idle1 = !m_busy[1] && !m_done[1];
    eb0 = m_done[0] ? m_bin[0] : 14'd0;
    eb1 = m_done[1] ? m_bin[1] : 14'd0;
    chk("d4 in_ready",   32'(in_ready4),   32'(idle0));
    chk("d4 out_valid",  32'(out_valid4),  32'(m_done[0]));
    chk("d4 out_binary", 32'(out_binary4), 32'(eb0));
    chk("d4 out_error",  32'(out_error4),  32'(m_done[0] && m_err[0]));
    chk("d2 in_ready",   32'(in_ready2),   32'(idle1));
    chk("d2 out_valid",  32'(out_valid2),  32'(m_done[1]));
    chk("d2 out_binary", 32'(out_binary2), 32'(eb1));
    chk("d2 out_error",  32'(out_error2),  32'(m_done[1] && m_err[1]));
  end

  // Sweep receiver: a transfer happens at the next edge when both are high.
  always @(negedge clk) begin
    if (sweep_on && out_valid2 && out_ready_s[1]) begin
      rx_count++;
      if (exp_q.size() == 0) begin
        chk("sweep extra result", 32'(out_binary2), 32'hFFFF_FFFF);
      end else begin
        chk("sweep result", 32'(out_binary2), 32'(exp_q.pop_front()));
      end
    end
  end

  // One 4-digit conversion: measures latency, optional stall, handshake.
  task automatic run4(input logic [15:0] bcd, input logic [13:0] exp_b,
                      input logic exp_e, input int stall, input string nm);
    int lat;
    bit got;
    for (int i = 0; i < 50 && !in_ready4; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, " ready before"}, 32'(in_ready4), 32'd1);
    in_valid_s[0] = 1'b1;
    in_bcd_s[0]   = bcd;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (out_valid4) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'd14);
    chk({nm, " binary"},  32'(out_binary4), 32'(exp_b));
    chk({nm, " error"},   32'(out_error4),  32'(exp_e));
    chk({nm, " busy"},    32'(in_ready4),   32'd0);
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
      end
      chk({nm, " held valid"},  32'(out_valid4),  32'd1);
      chk({nm, " held binary"}, 32'(out_binary4), 32'(exp_b));
      chk({nm, " held busy"},   32'(in_ready4),   32'd0);
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[0] = 1'b0;
    chk({nm, " valid drop"}, 32'(out_valid4), 32'd0);
    chk({nm, " ready back"}, 32'(in_ready4),  32'd1);
  endtask

  initial begin
    logic [13:0] rv;
    logic        re;
    logic [15:0] rb;
    int          st;

    for (int k = 0; k < 2; k++) begin
      in_valid_s[k]  = 1'b0;
      out_ready_s[k] = 1'b0;
      in_bcd_s[k]    = 16'h0;
    end

    // Reference function pinned to hand-computed values.
    ref_conv(16'h1234, 4, rv, re);
    chk("ref 1234", 32'(rv), 32'd1234);
    ref_conv(16'h9999, 4, rv, re);
    chk("ref 9999", 32'(rv), 32'h270F);
    ref_conv(16'h12A4, 4, rv, re);
    chk("ref 12A4 err", 32'(re), 32'd1);
    ref_conv(16'h0099, 2, rv, re);
    chk("ref 99", 32'(rv), 32'd99);

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  32'(in_ready4),   32'd1);
    chk("reset out_valid", 32'(out_valid4),  32'd0);
    chk("reset binary",    32'(out_binary4), 32'd0);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;

    run4(16'h9999, 14'd9999, 1'b0, 0, "9999");
    run4(16'h1234, 14'd1234, 1'b0, 3, "1234");
    run4(16'h0000, 14'd0,    1'b0, 0, "0000");
    run4(16'h12A4, 14'd0,    1'b1, 2, "12A4");
    run4(16'h0567, 14'd567,  1'b0, 20, "backpressure");

    // Abort a conversion with an asynchronous reset mid-cycle.
    in_valid_s[0] = 1'b1;
    in_bcd_s[0]   = 16'h5678;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort in_ready",  32'(in_ready4),   32'd1);
    chk("abort out_valid", 32'(out_valid4),  32'd0);
    chk("abort binary",    32'(out_binary4), 32'd0);
    chk("abort error",     32'(out_error4),  32'd0);
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #1;
    run4(16'h0042, 14'd42, 1'b0, 0, "0042 after abort");

    // Random 4-digit inputs, some with invalid nibbles.
    for (int n = 0; n < 6; n++) begin
      if (n % 3 == 2) rb = 16'($urandom);
      else rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      ref_conv(rb, 4, rv, re);
      st = $urandom_range(0, 4);
      run4(rb, rv, re, st, "random");
    end

    // Exhaustive 2-digit sweep with random downstream stalls.
    sweep_on = 1'b1;
    fork
      begin
        for (int v = 0; v < 100; v++) begin
          bit acc;
          int bud;
          exp_q.push_back(7'(v));
          in_bcd_s[1]   = {8'h00, 4'(v / 10), 4'(v % 10)};
          in_valid_s[1] = 1'b1;
          acc = 1'b0;
          bud = 0;
          while (!acc && bud < 200) begin
            @(negedge clk);
            acc = in_ready2;
            @(posedge clk); #1;
            bud++;
          end
          if (!acc) chk("sweep accept timeout", 32'(v), 32'hFFFF_FFFF);
        end
        in_valid_s[1] = 1'b0;
        for (int i = 0; i < 2000 && rx_count < 100; i++) begin
          @(posedge clk); #1;
        end
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk); #1;
          out_ready_s[1] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready_s[1] = 1'b0;
    sweep_on = 1'b0;
    chk("sweep count",   32'(rx_count),     32'd100);
    chk("sweep leftover", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
